// File: rtl/izz_pkg.sv
// Shared constants and types for the de-zigzag double buffer:
// zigzag-to-raster map, bank-state encoding and block geometry.
package izz_pkg;

  localparam int COEF_W_DEFAULT = 12;
  localparam logic [5:0] BLK_LAST = 6'd63;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  // Zigzag index k -> raster position (row*8 + col).
  localparam logic [5:0] ZZ2RASTER [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/izz_bank.sv
// One 64-entry coefficient bank: synchronous write, combinational read.
// Contents are deliberately not reset.
module izz_bank
  import izz_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEFAULT
) (
  input  logic              clk,
  input  logic              we,
  input  logic [5:0]        wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic [5:0]        rd_addr,
  output logic [COEF_W-1:0] rd_data
);

  logic [COEF_W-1:0] mem [64];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/izz_dezigzag_buf.sv
// Ping-pong zigzag-to-raster reorder buffer for the decode path.
// Optional IZZ_SOB_RESYNC_EN: in_sob mid-block restarts the fill and pulses sob_err.
module izz_dezigzag_buf
  import izz_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sob,
  input  logic [COEF_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_data,
  output logic              out_sob,
  output logic              out_eob,
  output logic              sob_err
);

  bank_state_e bank_state_reg [2];
  bank_state_e bank_state_next [2];
  logic        wr_bank_reg, rd_bank_reg, out_bank_reg;
  logic [5:0]  wr_k_reg, rd_r_reg;
  logic        out_valid_reg, out_sob_reg, out_eob_reg, sob_err_reg;
  logic [COEF_W-1:0] out_data_reg;

  logic [1:0][COEF_W-1:0] rd_data;
  logic [5:0]  wr_addr;
  logic        wr_fire, wr_done, resync;
  logic        out_fire, out_free, rd_avail, ld_fire;

  assign in_ready = (bank_state_reg[wr_bank_reg] == EMPTY) ||
                    (bank_state_reg[wr_bank_reg] == FILLING);
  assign wr_fire  = ena & in_valid & in_ready;

`ifdef IZZ_SOB_RESYNC_EN
  assign resync = wr_fire & in_sob & (wr_k_reg != 6'd0);
`else
  logic unused_in_sob;
  assign unused_in_sob = in_sob;
  assign resync = 1'b0;
`endif

  assign wr_done  = wr_fire & ~resync & (wr_k_reg == BLK_LAST);
  assign wr_addr  = resync ? 6'd0 : ZZ2RASTER[wr_k_reg];
  assign out_fire = ena & out_valid_reg & out_ready;
  assign out_free = ~out_valid_reg | out_ready;
  // Raster 0 is always already stored once the fill reaches k=63, so the
  // drain may start on the same edge that completes the block.
  assign rd_avail = (bank_state_reg[rd_bank_reg] == FULL) ||
                    (bank_state_reg[rd_bank_reg] == DRAINING) ||
                    (wr_done && (wr_bank_reg == rd_bank_reg));
  assign ld_fire  = ena & out_free & rd_avail;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      izz_bank #(.COEF_W(COEF_W)) u_bank (
        .clk     (clk),
        .we      (wr_fire && (wr_bank_reg == 1'(gi))),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_addr (rd_r_reg),
        .rd_data (rd_data[gi])
      );
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bank_state_next[i] = bank_state_reg[i];
      if (wr_fire && (wr_bank_reg == 1'(i))) begin
        bank_state_next[i] = wr_done ? FULL : FILLING;
      end
      if (ld_fire && (rd_bank_reg == 1'(i)) && (rd_r_reg == 6'd0)) begin
        bank_state_next[i] = DRAINING;
      end
      // A bank is released only when its last beat leaves the output register.
      if (out_fire && out_eob_reg && (out_bank_reg == 1'(i))) begin
        bank_state_next[i] = EMPTY;
      end
    end
  end

  // rd_r/rd_bank address the next beat to load, one ahead of the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_state_reg <= '{EMPTY, EMPTY};
      wr_bank_reg    <= 1'b0;
      rd_bank_reg    <= 1'b0;
      out_bank_reg   <= 1'b0;
      wr_k_reg       <= 6'd0;
      rd_r_reg       <= 6'd0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_sob_reg    <= 1'b0;
      out_eob_reg    <= 1'b0;
      sob_err_reg    <= 1'b0;
    end else if (ena) begin
      bank_state_reg <= bank_state_next;
      sob_err_reg    <= resync;
      if (wr_fire) begin
        wr_k_reg <= resync ? 6'd1 : wr_k_reg + 6'd1;
        if (wr_done) begin
          wr_bank_reg <= ~wr_bank_reg;
        end
      end
      if (ld_fire) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= rd_data[rd_bank_reg];
        out_sob_reg   <= (rd_r_reg == 6'd0);
        out_eob_reg   <= (rd_r_reg == BLK_LAST);
        out_bank_reg  <= rd_bank_reg;
        rd_r_reg      <= rd_r_reg + 6'd1;
        if (rd_r_reg == BLK_LAST) begin
          rd_bank_reg <= ~rd_bank_reg;
        end
      end else if (out_fire) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sob   = out_sob_reg;
  assign out_eob   = out_eob_reg;
  assign sob_err   = sob_err_reg;

endmodule

// File: tb/tb_izz_dezigzag_buf.sv
// Scoreboard bench for izz_dezigzag_buf: directed blocks, expected raster
// order pushed at stimulus time, monitor pops on each output handshake.
module tb_izz_dezigzag_buf;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_sob = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, out_sob, out_eob, sob_err;
  logic [W-1:0] out_data;

  izz_dezigzag_buf #(.COEF_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sob    (in_sob),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sob   (out_sob),
    .out_eob   (out_eob),
    .sob_err   (sob_err)
  );

  always #5 clk = ~clk;

  // Raster position r -> zigzag index holding it (standard JPEG matrix).
  int r2z [64] = '{
     0,  1,  5,  6, 14, 15, 27, 28,
     2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,
     9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54,
    20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61,
    35, 36, 48, 49, 57, 58, 62, 63
  };

  typedef struct packed {
    logic [W-1:0] data;
    logic         sob;
    logic         eob;
  } exp_t;

  exp_t exp_q [$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  logic         stall_prev = 1'b0;
  logic [W-1:0] held_data;
  logic [1:0]   held_flags;
  bit   stream_win = 0, stream_started = 0, rand_en = 0;
  int   gaps = 0, ready_drops = 0, sob_err_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: samples mid-cycle, handshake completes at the following posedge.
  always @(negedge clk) begin
    if (rst) begin
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(held_data));
        check("stall_flags", 32'({out_sob, out_eob}), 32'(held_flags));
      end
      if (sob_err) sob_err_pulses++;
      if (stream_win) begin
        if (!in_ready) ready_drops++;
        if (stream_started && !out_valid && exp_q.size() != 0) gaps++;
      end
      if (out_valid && out_ready && ena) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out: got data 0x%0h, expected no output", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_sob_eob", 32'({out_sob, out_eob}), 32'({e.sob, e.eob}));
        end
        if (stream_win) stream_started = 1;
      end
      stall_prev = out_valid && !(out_ready && ena);
      held_data  = out_data;
      held_flags = {out_sob, out_eob};
    end else begin
      stall_prev = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rand_en) begin
      #1;
      ena       = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic send(input logic [W-1:0] d, input logic sob);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sob   = sob;
    forever begin
      @(negedge clk);
      if (in_ready && ena) break;
      guard++;
      if (guard > 2000) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: in_ready low for 2000 cycles, expected acceptance");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sob   = 1'b0;
  endtask

  task automatic push_block(input int base);
    for (int r = 0; r < 64; r++) begin
      exp_q.push_back('{data: W'(base + r2z[r]), sob: (r == 0), eob: (r == 63)});
    end
  endtask

  task automatic send_block(input int base);
    push_block(base);
    for (int k = 0; k < 64; k++) send(W'(base + k), k == 0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_sob_eob", 32'({out_sob, out_eob}), 32'd0);
    check("rst_sob_err", 32'(sob_err), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single block, data = k: first beat appears right after the 64th write.
    push_block(0);
    for (int k = 0; k < 63; k++) send(W'(k), k == 0);
    check("t1_valid_before_last", 32'(out_valid), 32'd0);
    send(W'(63), 1'b0);
    check("t1_latency_valid", 32'(out_valid), 32'd1);
    check("t1_latency_sob", 32'(out_sob), 32'd1);
    wait_drain("t1_drain", 200);

    // Three blocks back to back with both sides always ready.
    stream_win = 1;
    stream_started = 0;
    for (int b = 1; b <= 3; b++) send_block(b * 256);
    wait_drain("t2_drain", 200);
    stream_win = 0;
    check("t2_in_ready_drops", 32'(ready_drops), 32'd0);
    check("t2_output_gaps", 32'(gaps), 32'd0);

    // Downstream stalled while two blocks fill both banks.
    out_ready = 1'b0;
    push_block(12'h400);
    push_block(12'h500);
    for (int k = 0; k < 64; k++) send(W'(12'h400 + k), k == 0);
    for (int k = 0; k < 63; k++) send(W'(12'h500 + k), k == 0);
    check("t3_ready_before_128", 32'(in_ready), 32'd1);
    send(W'(12'h53F), 1'b0);
    check("t3_ready_after_128", 32'(in_ready), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("t3_ready_still_low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(out_valid && out_ready && out_eob) && n < 200);
      check("t3_eob_seen", 32'(n < 200), 32'd1);
      check("t3_ready_low_at_last", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("t3_ready_return", 32'(in_ready), 32'd1);
      check("t3_block1_first", 32'(exp_q.size()), 32'd64);
    end
    wait_drain("t3_drain", 200);

    // Random ena / out_ready over four blocks.
    rand_en = 1;
    for (int b = 0; b < 4; b++) send_block(12'h600 + b * 64);
    wait_drain("t4_drain", 4000);
    rand_en = 0;
    @(posedge clk);
    #2;
    ena = 1'b1;
    out_ready = 1'b1;

    // Reset in the middle of a fill; only the fresh block may appear.
    for (int k = 0; k < 30; k++) send(W'(12'h700 + k), k == 0);
    rst = 1'b0;
    #1;
    check("t5_rst_in_ready", 32'(in_ready), 32'd1);
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_block(12'h780);
    wait_drain("t5_drain", 200);

`ifdef IZZ_SOB_RESYNC_EN
    sob_err_pulses = 0;
    for (int k = 0; k < 20; k++) send(W'(12'h800 + k), k == 0);
    push_block(12'h900);
    send(W'(12'h900), 1'b1);
    check("t6_sob_err_pulse", 32'(sob_err), 32'd1);
    send(W'(12'h901), 1'b0);
    check("t6_sob_err_clear", 32'(sob_err), 32'd0);
    for (int k = 2; k < 64; k++) send(W'(12'h900 + k), 1'b0);
    wait_drain("t6_drain", 200);
    check("t6_sob_err_count", 32'(sob_err_pulses), 32'd1);
`else
    // in_sob mid-block must be ignored: alignment by count only.
    push_block(12'h900);
    for (int k = 0; k < 64; k++) send(W'(12'h900 + k), (k == 0) || (k == 20));
    wait_drain("t6_drain", 200);
    check("t6_sob_err_never", 32'(sob_err_pulses), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 50000 cycles, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/izz_dezigzag_buf.md
Name: izz_dezigzag_buf

Overview:
Inverse of the encoder's fdct_zigzag reorder stage, used on the decode path.
- Accepts 8x8 blocks of quantised DCT coefficients arriving in zigzag order.
- Emits each block in raster order (row-major, index r = row*8 + col) to the IDCT MAC units.
- Double-buffered (ping-pong), so one block fills while the previous one drains.

Parameters:
COEF_W, 12, coefficient width in bits (signed, passed through unmodified)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
ena  in  1  clock enable; when low, all state and outputs hold
in_valid  in  1  input coefficient valid
in_ready  out  1  input accepted when in_valid & in_ready & ena
in_sob  in  1  start-of-block marker, qualified with in_valid
in_data  in  COEF_W  coefficient in zigzag order
out_valid  out  1  output coefficient valid
out_ready  in  1  downstream accepts when out_valid & out_ready & ena
out_data  out  COEF_W  coefficient in raster order
out_sob  out  1  high with raster index 0 of each block
out_eob  out  1  high with raster index 63 of each block
sob_err  out  1  one-cycle pulse on in_sob resync (feature only; tied 0 otherwise)

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_sob=0, out_eob=0, sob_err=0. Both banks EMPTY, wr_bank=0, rd_bank=0, wr_k=0, rd_r=0. Bank contents are not reset.
- Bank states: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  - EMPTY -> FILLING on the first write.
  - FILLING -> FULL on the write with wr_k=63.
  - FULL -> DRAINING when selected as rd_bank and the output register is free.
  - DRAINING -> EMPTY when the beat with rd_r=63 is accepted.
- Write side:
  - Accepted beat with zigzag index wr_k is stored at ZZ2RASTER[wr_k] of wr_bank; wr_k then increments.
  - At wr_k=63: wr_k wraps to 0 and wr_bank toggles.
  - in_ready = (wr_bank state is EMPTY or FILLING).
- Read side:
  - out_data is registered. out_valid rises 1 cycle after rd_bank becomes FULL.
  - Latency: last input beat accepted at cycle t gives first output at cycle t+1 (if the output register is free).
  - rd_r increments on each accepted output beat. After rd_r=63 is accepted, rd_bank toggles and rd_r wraps to 0.
  - Back-to-back blocks stream at 1 beat/cycle with no bubbles when both sides are continuously ready.
  - out_data/out_sob/out_eob are held stable while out_valid & ~out_ready.
- Simultaneous events:
  - Write completing bank A in the same cycle the final read of bank B is accepted: both transitions take effect, with no lost or duplicated beat.
  - The same bank is never written and read in the same cycle (state guarantees this).
- Full condition: both banks FULL/DRAINING -> in_ready=0 until a drain completes. in_ready reasserts the cycle after the final beat's acceptance.
- in_sob without the feature: ignored. Block alignment is purely by count.
- Reset mid-block: partial block discarded, all state returns to reset values immediately (asynchronous).
- ena low: no state change. Handshakes are not counted. Outputs hold.

Optional Feature:
IZZ_SOB_RESYNC_EN
- Defined: an accepted beat with in_sob=1 while wr_k!=0 aborts the partial fill.
  - The bank returns to FILLING with wr_k=0 and stores this beat as zigzag index 0.
  - sob_err pulses for 1 cycle.
  - in_sob=1 at wr_k=0 is normal; no pulse.
- Undefined: in_sob is ignored and sob_err is tied to 0.

Decomposition:
- Package izz_pkg:
  - ZZ2RASTER 64-entry 6-bit constant table.
  - Bank-state enum typedef (EMPTY/FILLING/FULL/DRAINING).
  - COEF_W_DEFAULT=12.
  - Constant BLK_LAST=63.
- Sub-module izz_bank: 64 x COEF_W storage with 1 synchronous write port and 1 combinational read port. Instantiated twice.
- Top level holds both bank FSMs, the pointers and the output register.

Test Plan:
- Write in_data=k for zigzag k=0..63, out_ready=1 -> outputs r0=0, r1=1, r2=5, r3=6, r8=2, r9=4, r16=3, r63=63. out_sob with r0, out_eob with r63, first out_valid 1 cycle after the 64th write.
- Three blocks back-to-back (values 0x100+k, 0x200+k, 0x300+k), out_ready=1 -> 192 outputs on consecutive cycles, in_ready never drops, no data mixing.
- out_ready=0 while 2 blocks are written -> in_ready=0 after the 128th write. Raising out_ready drains block 1 first. in_ready returns the cycle after rd_r=63 of block 1 is accepted.
- Random out_ready/ena toggling over 4 blocks -> output sequence identical to the reference permutation, and out_data stable while stalled.
- rst asserted after 30 writes, then a fresh block written -> no stale data output, first output equals the new block's k=0 value.
- With IZZ_SOB_RESYNC_EN: in_sob at wr_k=20 -> sob_err pulses once, next 64 beats form a correct block, the aborted 20 beats never appear.
